instruction_fetch: RTL

Fetch stage of the RISC-V core. Holds the program counter, issues word requests to instruction memory over a request/response handshake, and presents the returned instruction word and its opcode field to the decode logic and the immediate sign-extension unit. Advances the PC sequentially or to a redirect target supplied by the execute logic, and stops in a fault state on a misaligned target.

---
 rtl/instruction_fetch.sv | 117 +++++++++++
 1 files changed

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, fetches one word per instruction over a req/ready,
// rvalid/rdata memory interface and holds it for decode until consumed.
`ifndef INST_WIDTH
`define INST_WIDTH 32
`endif

module instruction_fetch #(
  parameter logic [`INST_WIDTH-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_stall,
  input  logic                   i_redirect,
  input  logic [`INST_WIDTH-1:0] i_redirect_pc,
  output logic                   o_imem_req,
  output logic [`INST_WIDTH-1:0] o_imem_addr,
  input  logic                   i_imem_ready,
  input  logic                   i_imem_rvalid,
  input  logic [`INST_WIDTH-1:0] i_imem_rdata,
  output logic                   o_inst_valid,
  output logic [`INST_WIDTH-1:0] o_inst,
  output logic [6:0]             o_opcode,
  output logic [`INST_WIDTH-1:0] o_pc,
  output logic [`INST_WIDTH-1:0] o_pc_plus4,
  output logic                   o_fault,
  output logic [2:0]             o_dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_HOLD  = 3'd3,
    S_FAULT = 3'd4
  } state_e;

  localparam logic [`INST_WIDTH-1:0] NOP = 32'h0000_0013;

  state_e                   state_q;
  logic [`INST_WIDTH-1:0]   pc_q;
  logic [`INST_WIDTH-1:0]   inst_q;
  logic                     req_q;
  logic                     inst_valid_q;
  logic                     fault_q;
  logic [`INST_WIDTH-1:0]   pc_plus4;
  logic [`INST_WIDTH-1:0]   next_pc_d;

  assign pc_plus4  = pc_q + 32'd4;
  assign next_pc_d = i_redirect ? i_redirect_pc : pc_plus4;

  // Handshakes: a request transfers on a cycle with o_imem_req && i_imem_ready,
  // address held stable until then; the response transfers on any cycle with
  // i_imem_rvalid while waiting for it. Decode consumes o_inst on any cycle with
  // o_inst_valid && !i_stall.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q      <= S_IDLE;
      pc_q         <= RESET_PC;
      inst_q       <= NOP;
      req_q        <= 1'b0;
      inst_valid_q <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_q <= S_REQ;
          req_q   <= 1'b1;
        end
        S_REQ: begin
          if (i_imem_ready) begin
            state_q <= S_WAIT;
            req_q   <= 1'b0;
          end
        end
        S_WAIT: begin
          if (i_imem_rvalid) begin
            inst_q       <= i_imem_rdata;
            inst_valid_q <= 1'b1;
            state_q      <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (!i_stall) begin
            inst_valid_q <= 1'b0;
            // A misaligned target is fatal; the PC keeps the faulting instruction.
            if (next_pc_d[1:0] != 2'b00) begin
              state_q <= S_FAULT;
              fault_q <= 1'b1;
            end else begin
              pc_q    <= next_pc_d;
              state_q <= S_REQ;
              req_q   <= 1'b1;
            end
          end
        end
        S_FAULT: begin
          state_q <= S_FAULT;
        end
        default: begin
          state_q <= S_FAULT;
          fault_q <= 1'b1;
        end
      endcase
    end
  end

  assign o_imem_req   = req_q;
  assign o_imem_addr  = pc_q;
  assign o_inst_valid = inst_valid_q;
  assign o_inst       = inst_q;
  assign o_opcode     = inst_q[6:0];
  assign o_pc         = pc_q;
  assign o_pc_plus4   = pc_plus4;
  assign o_fault      = fault_q;
  assign o_dbg_state  = state_q;

endmodule
